// File: rtl/hole_hit_detector.sv
// Per-ball hole-overlap counter; decides pocketed balls at each frame
// boundary and holds them pending until the game controller acknowledges.
module hole_hit_detector #(
  parameter int unsigned NUM_BALLS     = 16,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned HIT_THRESHOLD = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 startOfFrame,
  input  logic                 drawingRequestHole,
  input  logic [NUM_BALLS-1:0] drawingRequestBalls,
  input  logic [NUM_BALLS-1:0] ballActive,
  input  logic                 sunkAck,
  output logic [NUM_BALLS-1:0] sunkMask,
  output logic                 sunkValid,
  output logic                 cueSunk,
  output logic                 frameDone
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(HIT_THRESHOLD);

  typedef enum logic {
    SYNC  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q [NUM_BALLS];
  logic [CNT_W-1:0]       cnt_d [NUM_BALLS];
  logic [NUM_BALLS-1:0]   mask_q, mask_d;
  logic                   valid_q, valid_d;
  logic                   cue_q, cue_d;
  logic                   frame_done_q, frame_done_d;

  logic [NUM_BALLS-1:0]   ov;
  logic [NUM_BALLS-1:0]   hit;
  logic                   eval;
  logic                   ack_eff;

  // Next-state: frame sync, overlap counting, evaluation and pending mask.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    frame_done_d = 1'b0;
    hit          = '0;
    eval         = 1'b0;
    ov           = drawingRequestBalls & ballActive & {NUM_BALLS{drawingRequestHole}};
    ack_eff      = sunkAck & valid_q;

    case (state_q)
      SYNC: begin
        // Frame in progress at reset is partial: hold counters at zero.
        for (int i = 0; i < NUM_BALLS; i++) begin
          cnt_d[i] = '0;
        end
        if (startOfFrame) begin
          state_d = ACCUM;
          for (int i = 0; i < NUM_BALLS; i++) begin
            cnt_d[i] = ov[i] ? CNT_W'(1) : '0;
          end
        end
      end
      ACCUM: begin
        if (startOfFrame) begin
          eval         = 1'b1;
          frame_done_d = 1'b1;
          for (int i = 0; i < NUM_BALLS; i++) begin
            hit[i]   = ballActive[i] & (cnt_q[i] >= THR);
            // The startOfFrame pixel already belongs to the new frame.
            cnt_d[i] = ov[i] ? CNT_W'(1) : '0;
          end
        end else begin
          for (int i = 0; i < NUM_BALLS; i++) begin
            if (ov[i] && (cnt_q[i] != CNT_MAX)) begin
              cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase

    // An ack coinciding with an evaluation must not drop the new hits.
    if (eval && ack_eff) begin
      mask_d = hit;
    end else if (ack_eff) begin
      mask_d = '0;
    end else if (eval) begin
      mask_d = mask_q | hit;
    end

    valid_d = |mask_d;
    cue_d   = mask_d[0];
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      mask_q       <= '0;
      valid_q      <= 1'b0;
      cue_q        <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      valid_q      <= valid_d;
      cue_q        <= cue_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < NUM_BALLS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sunkMask  = mask_q;
  assign sunkValid = valid_q;
  assign cueSunk   = cue_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_hole_hit_detector.sv
// Directed bench for hole_hit_detector with hand-computed expectations.
module tb_hole_hit_detector;

  logic        clk;
  logic        rst;
  logic        startOfFrame;
  logic        drawingRequestHole;
  logic [15:0] drawingRequestBalls;
  logic [15:0] ballActive;
  logic        sunkAck;
  logic [15:0] sunkMask;
  logic        sunkValid;
  logic        cueSunk;
  logic        frameDone;

  int errors = 0;
  int checks = 0;

  hole_hit_detector #(
    .NUM_BALLS    (16),
    .CNT_W        (10),
    .HIT_THRESHOLD(40)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .startOfFrame       (startOfFrame),
    .drawingRequestHole (drawingRequestHole),
    .drawingRequestBalls(drawingRequestBalls),
    .ballActive         (ballActive),
    .sunkAck            (sunkAck),
    .sunkMask           (sunkMask),
    .sunkValid          (sunkValid),
    .cueSunk            (cueSunk),
    .frameDone          (frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one pixel at a negedge; returns at the next negedge with results visible.
  task automatic tick(input logic sof, input logic hole, input logic [15:0] balls,
                      input logic ack);
    startOfFrame        = sof;
    drawingRequestHole  = hole;
    drawingRequestBalls = balls;
    sunkAck             = ack;
    @(negedge clk);
  endtask

  task automatic overlap(input int idx, input int n);
    logic [15:0] b;
    b      = '0;
    b[idx] = 1'b1;
    for (int k = 0; k < n; k++) tick(1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic sof_idle();
    tick(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic ack_only();
    tick(1'b0, 1'b0, 16'h0000, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(1'b0, 1'b0, 16'h0000, 1'b0);
    checks++;
    if (sunkMask !== 16'h0000 || sunkValid !== 1'b0 || cueSunk !== 1'b0 || frameDone !== 1'b0) begin
      errors++;
      $display("FAIL reset: mask=%h valid=%b cue=%b fd=%b, required 0000/0/0/0",
               sunkMask, sunkValid, cueSunk, frameDone);
    end
    rst = 1'b0;
  endtask

  task automatic test_sync_discard();
    overlap(2, 100);
    sof_idle();
    checks++;
    if (frameDone !== 1'b0 || sunkMask !== 16'h0000) begin
      errors++;
      $display("FAIL sync_discard: fd=%b mask=%h, required 0/0000", frameDone, sunkMask);
    end
  endtask

  task automatic test_basic_hit();
    overlap(3, 50);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0008 || sunkValid !== 1'b1 || cueSunk !== 1'b0 || frameDone !== 1'b1) begin
      errors++;
      $display("FAIL basic_hit: mask=%h valid=%b cue=%b fd=%b, required 0008/1/0/1",
               sunkMask, sunkValid, cueSunk, frameDone);
    end
    ack_only();
    checks++;
    if (frameDone !== 1'b0 || sunkMask !== 16'h0000 || sunkValid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack: fd=%b mask=%h valid=%b, required 0/0000/0",
               frameDone, sunkMask, sunkValid);
    end
  endtask

  task automatic test_threshold();
    overlap(5, 39);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0000 || frameDone !== 1'b1) begin
      errors++;
      $display("FAIL thr_39: mask=%h fd=%b, required 0000/1", sunkMask, frameDone);
    end
    overlap(5, 40);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0020) begin
      errors++;
      $display("FAIL thr_40: mask=%h, required 0020", sunkMask);
    end
    ack_only();
  endtask

  task automatic test_saturation();
    // 1050 would wrap to 26 (below threshold) without saturation.
    overlap(0, 1050);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0001 || cueSunk !== 1'b1) begin
      errors++;
      $display("FAIL saturation: mask=%h cue=%b, required 0001/1", sunkMask, cueSunk);
    end
    ack_only();
  endtask

  task automatic test_accumulate_and_collision();
    overlap(3, 50);
    sof_idle();
    overlap(7, 50);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0088) begin
      errors++;
      $display("FAIL accumulate: mask=%h, required 0088", sunkMask);
    end
    ack_only();
    overlap(3, 50);
    sof_idle();
    overlap(7, 50);
    tick(1'b1, 1'b0, 16'h0000, 1'b1);
    checks++;
    if (sunkMask !== 16'h0080) begin
      errors++;
      $display("FAIL ack_collision: mask=%h, required 0080", sunkMask);
    end
    ack_only();
    checks++;
    if (sunkMask !== 16'h0000 || sunkValid !== 1'b0) begin
      errors++;
      $display("FAIL ack_alone: mask=%h valid=%b, required 0000/0", sunkMask, sunkValid);
    end
  endtask

  task automatic test_back_to_back();
    overlap(4, 50);
    sof_idle();
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0010 || frameDone !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back: mask=%h fd=%b, required 0010/1", sunkMask, frameDone);
    end
    ack_only();
    // Overlapping startOfFrame pixel counts toward the new frame: 1 + 39 = 40.
    tick(1'b1, 1'b1, 16'h0040, 1'b0);
    overlap(6, 39);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0040) begin
      errors++;
      $display("FAIL sof_pixel: mask=%h, required 0040", sunkMask);
    end
    ack_only();
  endtask

  task automatic test_inactive_and_reset();
    overlap(8, 50);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0100) begin
      errors++;
      $display("FAIL pend_8: mask=%h, required 0100", sunkMask);
    end
    // Ball 9 drops out after 30 cycles while still overlapping.
    overlap(9, 30);
    ballActive[9] = 1'b0;
    overlap(9, 30);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0100) begin
      errors++;
      $display("FAIL inactive_eval: mask=%h, required 0100", sunkMask);
    end
    // Reactivated before evaluation: only the 30 active cycles count.
    ballActive[9] = 1'b1;
    overlap(9, 30);
    ballActive[9] = 1'b0;
    overlap(9, 30);
    ballActive[9] = 1'b1;
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0100) begin
      errors++;
      $display("FAIL inactive_stop: mask=%h, required 0100", sunkMask);
    end
    // Mid-frame reset drops the pending mask and the partial frame.
    overlap(1, 20);
    rst = 1'b1;
    tick(1'b0, 1'b1, 16'h0002, 1'b0);
    rst = 1'b0;
    checks++;
    if (sunkMask !== 16'h0000 || sunkValid !== 1'b0 || frameDone !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: mask=%h valid=%b fd=%b, required 0000/0/0",
               sunkMask, sunkValid, frameDone);
    end
    overlap(1, 50);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0000 || frameDone !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_sync: mask=%h fd=%b, required 0000/0", sunkMask, frameDone);
    end
    overlap(1, 50);
    sof_idle();
    checks++;
    if (sunkMask !== 16'h0002 || frameDone !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_hit: mask=%h fd=%b, required 0002/1", sunkMask, frameDone);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    startOfFrame        = 1'b0;
    drawingRequestHole  = 1'b0;
    drawingRequestBalls = '0;
    ballActive          = 16'hFFFF;
    sunkAck             = 1'b0;
    @(negedge clk);
    test_reset();
    test_sync_discard();
    test_basic_hit();
    test_threshold();
    test_saturation();
    test_accumulate_and_collision();
    test_back_to_back();
    test_inactive_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
